activation_output_packer: RTL



---
 rtl/activation_output_packer_if.sv | 31 +++
 rtl/activation_output_packer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/activation_output_packer_if.sv
// ----------------------------------------------------------------------------
// activation_output_packer_if
//   Packed-word bus from the activation output packer to the memory write path.
//   The master presents the FIFO head; the slave accepts it with out_word_ready.
//
//   out_word_valid  master -> slave  head entry present
//   out_word_ready  slave  -> master head accepted this cycle
//   out_word        master -> slave  DATA_WIDTH*LANES packed word, lane 0 in LSBs
//   out_word_strb   master -> slave  bit i set = lane i holds a real feature
//   out_word_last   master -> slave  final word of the layer
// ----------------------------------------------------------------------------
interface activation_output_packer_if #(
   parameter int DATA_WIDTH = 32,
   parameter int LANES      = 16
) ();
   logic                        out_word_valid;
   logic                        out_word_ready;
   logic [DATA_WIDTH*LANES-1:0] out_word;
   logic [LANES-1:0]            out_word_strb;
   logic                        out_word_last;

   modport master (
      output out_word_valid, out_word, out_word_strb, out_word_last,
      input  out_word_ready
   );

   modport slave (
      input  out_word_valid, out_word, out_word_strb, out_word_last,
      output out_word_ready
   );
endinterface

// File: rtl/activation_output_packer.sv
// ----------------------------------------------------------------------------
// activation_output_packer
//   Collects the valid-only activated-feature stream, packs LANES features per
//   word (lane 0 in the LSBs), buffers words in a FIFO_DEPTH-entry FIFO and
//   offers them over a valid/ready bus. The stream cannot be stalled, so a
//   word completed while the FIFO is full is dropped and overflow sticks.
//
//   core_clk, resetn                 clock, asynchronous active-low reset
//   start                            one-cycle pulse beginning a layer
//   layer_config_out_features_count  features in the layer, sampled on start
//   activated_feature_valid/_feature incoming feature beat
//   out_bus (master)                 packed word, strobe, last, valid/ready
//   busy                             layer in progress
//   done                             one-cycle pulse at layer completion
//   overflow                         sticky: a packed word was dropped
// ----------------------------------------------------------------------------
module activation_output_packer #(
   parameter int DATA_WIDTH  = 32,
   parameter int LANES       = 16,
   parameter int FIFO_DEPTH  = 4,
   parameter int COUNT_WIDTH = 16
) (
   input  logic                        core_clk,
   input  logic                        resetn,
   input  logic                        start,
   input  logic [COUNT_WIDTH-1:0]      layer_config_out_features_count,
   input  logic                        activated_feature_valid,
   input  logic [DATA_WIDTH-1:0]       activated_feature,
   activation_output_packer_if.master  out_bus,
   output logic                        busy,
   output logic                        done,
   output logic                        overflow
);
   localparam int WORD_W  = DATA_WIDTH * LANES;
   localparam int LANE_W  = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int ADDR_W  = $clog2(FIFO_DEPTH);
   localparam int ENTRY_W = WORD_W + LANES + 1;

   typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;

   state_t                 state;
   logic [COUNT_WIDTH-1:0] count_q;
   logic [COUNT_WIDTH-1:0] feat_cnt_q;
   logic [LANE_W-1:0]      lane_idx_q;
   logic [WORD_W-1:0]      pack_q;
   logic [LANES-1:0]       strb_q;
   logic                   done_q;
   logic                   overflow_q;

   // Entry layout: {last, strb, word}. Pointers carry one extra wrap bit so
   // full and empty are distinguishable.
   logic [ENTRY_W-1:0]     fifo_mem [FIFO_DEPTH];
   logic [ADDR_W:0]        wr_ptr;
   logic [ADDR_W:0]        rd_ptr;

   logic [ADDR_W:0]        fifo_level;
   logic                   fifo_empty;
   logic                   fifo_full;
   logic                   pop;
   logic                   beat;
   logic [COUNT_WIDTH-1:0] feat_cnt_next;
   logic                   is_final;
   logic                   word_done;
   logic                   push_ok;
   logic                   drain_done;
   logic [WORD_W-1:0]      pack_beat;
   logic [LANES-1:0]       strb_beat;
   logic [ENTRY_W-1:0]     head;

   assign fifo_level    = wr_ptr - rd_ptr;
   assign fifo_empty    = (fifo_level == '0);
   assign fifo_full     = (fifo_level == (ADDR_W+1)'(FIFO_DEPTH));
   assign pop           = !fifo_empty && out_bus.out_word_ready;
   assign beat          = (state == COLLECT) && activated_feature_valid;
   assign feat_cnt_next = feat_cnt_q + 1'b1;
   assign is_final      = (feat_cnt_next == count_q);
   assign word_done     = beat && ((lane_idx_q == LANE_W'(LANES - 1)) || is_final);
   // A pop in the same cycle frees the slot the push needs.
   assign push_ok       = word_done && (!fifo_full || pop);
   // Finish as soon as the FIFO is empty, including the cycle of the last pop.
   assign drain_done    = fifo_empty || ((fifo_level == (ADDR_W+1)'(1)) && pop);

   // Current pack register with this beat merged in, so a completing beat
   // lands in the pushed word without waiting a cycle.
   always_comb begin
      pack_beat = pack_q;
      strb_beat = strb_q;
      pack_beat[int'(lane_idx_q)*DATA_WIDTH +: DATA_WIDTH] = activated_feature;
      strb_beat[lane_idx_q] = 1'b1;
   end

   // NOTE: FIFO storage has no reset; only the pointers do. Reset empties the
   // FIFO and the outputs below are forced to zero while it is empty.
   always_ff @(posedge core_clk) begin
      if (push_ok) begin
         fifo_mem[wr_ptr[ADDR_W-1:0]] <= {is_final, strb_beat, pack_beat};
      end
   end

   // NOTE: all state updates use non-blocking assignments so every branch
   // sees the pre-edge values of the other registers.
   always_ff @(posedge core_clk or negedge resetn) begin
      if (!resetn) begin
         state      <= IDLE;
         count_q    <= '0;
         feat_cnt_q <= '0;
         lane_idx_q <= '0;
         pack_q     <= '0;
         strb_q     <= '0;
         done_q     <= 1'b0;
         overflow_q <= 1'b0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
      end else begin
         done_q <= 1'b0;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;

         case (state)
            IDLE: begin
               if (start) begin
                  overflow_q <= 1'b0;
                  if (layer_config_out_features_count != '0) begin
                     count_q    <= layer_config_out_features_count;
                     feat_cnt_q <= '0;
                     lane_idx_q <= '0;
                     pack_q     <= '0;
                     strb_q     <= '0;
                     state      <= COLLECT;
                  end else begin
                     done_q <= 1'b1;
                  end
               end
            end
            COLLECT: begin
               if (beat) begin
                  // The counter advances even when the word is dropped so
                  // the layer still terminates.
                  feat_cnt_q <= feat_cnt_next;
                  if (word_done) begin
                     pack_q     <= '0;
                     strb_q     <= '0;
                     lane_idx_q <= '0;
                     if (!push_ok)  overflow_q <= 1'b1;
                     if (is_final)  state      <= DRAIN;
                  end else begin
                     pack_q     <= pack_beat;
                     strb_q     <= strb_beat;
                     lane_idx_q <= lane_idx_q + 1'b1;
                  end
               end
            end
            DRAIN: begin
               if (drain_done) begin
                  done_q <= 1'b1;
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign head                   = fifo_mem[rd_ptr[ADDR_W-1:0]];
   assign out_bus.out_word_valid = !fifo_empty;
   assign out_bus.out_word       = fifo_empty ? '0 : head[WORD_W-1:0];
   assign out_bus.out_word_strb  = fifo_empty ? '0 : head[WORD_W +: LANES];
   assign out_bus.out_word_last  = fifo_empty ? 1'b0 : head[ENTRY_W-1];

   assign busy     = (state != IDLE);
   assign done     = done_q;
   assign overflow = overflow_q;
endmodule
